// File: rtl/lut_stream_seq.sv
// lut_stream_seq: frames the LUT source stream into exactly LUT_LEN beats through a 2-entry skid buffer
module lut_stream_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int LUT_LEN    = 1024,
    parameter int CNT_WIDTH  = 16,
    parameter int TIMEOUT    = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_req,
    input  logic                  frame_abort,
    output logic                  lut_start,
    input  logic                  s_ltvalid,
    input  logic [DATA_WIDTH-1:0] s_ltdata,
    input  logic                  s_ltlast,
    output logic                  s_ltready,
    output logic                  m_ltvalid,
    output logic [DATA_WIDTH-1:0] m_ltdata,
    output logic                  m_ltlast,
    input  logic                  m_ltready,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  len_err,
    output logic                  timeout_err,
    output logic [CNT_WIDTH-1:0]  beat_cnt
);
    localparam int IW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, STREAM, TAIL, FLUSH} state_t;
    state_t state, state_n;
    logic [IW-1:0] idle_cnt;
    logic [DATA_WIDTH-1:0] skid_data;
    logic skid_last, skid_valid, skid_valid_n;
    logic in_acc, out_acc, watch_idle, abort, idle_hit, tag_last, push, flush_buf, head_free;
    always_comb begin
        in_acc = s_ltvalid && s_ltready;
        out_acc = m_ltvalid && m_ltready;
        watch_idle = state == STREAM || state == FLUSH;
        abort = frame_abort && (state == STREAM || state == TAIL);
        idle_hit = watch_idle && !in_acc && idle_cnt == IW'(TIMEOUT - 1);
        tag_last = beat_cnt == CNT_WIDTH'(LUT_LEN - 1);
        state_n = state;
        case (state)
            IDLE:    state_n = frame_req ? STREAM : IDLE;
            STREAM:  state_n = (abort || idle_hit) ? FLUSH : (in_acc && tag_last) ? TAIL : STREAM;
            TAIL:    state_n = abort ? FLUSH : (out_acc && m_ltlast) ? IDLE : TAIL;
            FLUSH:   state_n = (idle_hit || (in_acc && s_ltlast)) ? IDLE : FLUSH;
            default: state_n = IDLE;
        endcase
        push = state == STREAM && in_acc && state_n != FLUSH;
        flush_buf = state_n == FLUSH && state != FLUSH;
        head_free = out_acc || !m_ltvalid;
        // skid entry only fills when the output register is held by backpressure
        skid_valid_n = !flush_buf && (skid_valid ? !out_acc : (push && !head_free));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            lut_start <= 1'b0;
            s_ltready <= 1'b0;
            busy <= 1'b0;
            frame_done <= 1'b0;
            len_err <= 1'b0;
            timeout_err <= 1'b0;
            beat_cnt <= '0;
            idle_cnt <= '0;
            m_ltvalid <= 1'b0;
            m_ltdata <= '0;
            m_ltlast <= 1'b0;
            skid_valid <= 1'b0;
            skid_data <= '0;
            skid_last <= 1'b0;
        end else begin
            state <= state_n;
            lut_start <= state_n == STREAM;
            busy <= state_n != IDLE;
            s_ltready <= state_n == FLUSH || (state_n == STREAM && !skid_valid_n);
            frame_done <= state == TAIL && state_n == IDLE;
            idle_cnt <= (state_n != state || in_acc || !watch_idle) ? '0 : idle_cnt + IW'(1);
            skid_valid <= skid_valid_n;
            if (state == IDLE && frame_req) begin
                beat_cnt <= '0;
                len_err <= 1'b0;
                timeout_err <= 1'b0;
            end
            if (state == STREAM && in_acc) begin
                beat_cnt <= beat_cnt + CNT_WIDTH'(1);
                len_err <= len_err || (s_ltlast != tag_last);
            end
            if (state == STREAM && idle_hit && !abort)
                timeout_err <= 1'b1;
            if (flush_buf) begin
                m_ltvalid <= 1'b0;
                m_ltlast <= 1'b0;
            end else if (head_free) begin
                m_ltvalid <= skid_valid || push;
                m_ltdata <= skid_valid ? skid_data : push ? s_ltdata : m_ltdata;
                m_ltlast <= skid_valid ? skid_last : (push && tag_last);
            end
            if (push && !head_free) begin
                skid_data <= s_ltdata;
                skid_last <= tag_last;
            end
        end
    end
endmodule
